// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, 1 stop bit, with rx_valid/rx_rd handshake and sticky overrun.
// Optional even-parity bit and parity_err output are enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int BIT_CLKS = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rx_rd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       rx_busy
);
    localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            sync1;
    logic            rxs;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            done;
    logic            stop_bit;
    logic            half_tick;
    logic            bit_tick;
    logic            cnt_clr;
`ifdef UART_RX_PARITY_EN
    logic            par_bit;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        half_tick  = (cnt == HALF_LAST);
        bit_tick   = (cnt == BIT_LAST);
        case (state)
            IDLE:      if (!rxs) state_next = START;
            START:     if (half_tick) state_next = rxs ? IDLE : DATA;
            DATA: begin
                if (bit_tick && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY:    if (bit_tick) state_next = STOP;
`endif
            STOP:      if (bit_tick) state_next = rxs ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rxs) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        // Counter restarts on every state change and at each full bit period,
        // so it tops out at BIT_CLKS-1 and never wraps mid-bit.
        cnt_clr = (state_next != state) || bit_tick || (state == IDLE) || (state == WAIT_HIGH);
    end

    assign rx_busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
            done     <= 1'b0;
            stop_bit <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            cnt  <= cnt_clr ? '0 : cnt + 1'b1;
            done <= 1'b0;
            if (state == START) bit_idx <= 3'd0;
            if (state == DATA && bit_tick) begin
                shreg   <= {rxs, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (state == PARITY && bit_tick) par_bit <= rxs;
`endif
            if (state == STOP && bit_tick) begin
                stop_bit <= rxs;
                done     <= 1'b1;
            end
        end
    end

    // A completing byte always wins; rx_rd in the same cycle only suppresses overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (done) begin
            rx_data    <= shreg;
            rx_valid   <= 1'b1;
            frame_err  <= ~stop_bit;
`ifdef UART_RX_PARITY_EN
            parity_err <= ^{shreg, par_bit};
`endif
            if (rx_rd)         overrun <= 1'b0;
            else if (rx_valid) overrun <= 1'b1;
        end else if (rx_rd && rx_valid) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end
endmodule
